// File: rtl/truth_table_checker.sv
// Built-in self-test for a single-output 4-input combinational function: sweeps all
// 16 ABCD vectors, samples f_in after a settle window and scores it against EXPECTED.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED      = 16'h6996,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic [3:0] abcd_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] vector_n;
  logic [4:0] err_n;
  logic [3:0] first_n;
  logic       fv_n, busy_n, done_n, pass_n;

  // The vector register drives the DUT directly, so abcd_out is 0 in IDLE and 15 in DONE.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_n  = state;
    cnt_n    = cnt;
    vector_n = abcd_out;
    err_n    = err_count;
    first_n  = first_fail;
    fv_n     = fail_valid;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = APPLY;
          cnt_n    = '0;
          vector_n = '0;
          err_n    = '0;
          first_n  = '0;
          fv_n     = 1'b0;
        end
      end
      APPLY: begin
        if (abort) begin
          state_n  = IDLE;
          cnt_n    = '0;
          vector_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_n  = IDLE;
          cnt_n    = '0;
          vector_n = '0;
        end else begin
          if (f_in != EXPECTED[abcd_out]) begin
            err_n = err_count + 5'd1;
            if (!fail_valid) begin
              first_n = abcd_out;
              fv_n    = 1'b1;
            end
          end
          if (abcd_out == 4'd15) begin
            state_n = DONE;
          end else begin
            state_n  = APPLY;
            vector_n = abcd_out + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Status flags are computed from the next state so they are registered, not decoded.
    busy_n = (state_n == APPLY) || (state_n == SAMPLE);
    done_n = (state_n == DONE);
    pass_n = (state_n == DONE) && (err_n == 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      abcd_out   <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      abcd_out   <= vector_n;
      err_count  <= err_n;
      first_fail <= first_n;
      fail_valid <= fv_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
    end
  end

endmodule
